// File: rtl/alu_seq.sv
// 8-bit ALU stage for the AC accumulator: single-cycle logic/arithmetic ops,
// a WIDTH-step shift-add multiply, registered Z/C/N/V flags and a one-cycle done pulse.
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic                 z_reg, z_next, c_reg, c_next, n_reg, n_next, v_reg, v_next;
  logic                 done_reg, done_next, busy_reg, busy_next;
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next, acc_reg, acc_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [CW-1:0]        cnt_reg, cnt_next;

  logic [WIDTH:0]       sum_ext, diff_ext;
  logic [WIDTH-1:0]     alu_r;
  logic                 alu_c, alu_v;
  logic [2*WIDTH-1:0]   acc_step;

  // Single-cycle datapath
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_v = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_r = diff_ext[WIDTH-1:0];
        alu_c = diff_ext[WIDTH];
        alu_v = (a[MSB] != b[MSB]) && (alu_r[MSB] != a[MSB]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_NOT: alu_r = ~a;
      OP_SHL: begin
        alu_r = {a[WIDTH-2:0], 1'b0};
        alu_c = a[MSB];
      end
      OP_SHR: begin
        alu_r = {1'b0, a[WIDTH-1:1]};
        alu_c = a[0];
      end
      default: alu_r = '0;
    endcase
  end

  assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    z_next      = z_reg;
    c_next      = c_reg;
    n_next      = n_reg;
    v_next      = v_reg;
    done_next   = 1'b0;
    busy_next   = busy_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_next  = {{WIDTH{1'b0}}, a};
            mplier_next = b;
            acc_next    = '0;
            cnt_next    = '0;
            busy_next   = 1'b1;
            state_next  = MUL;
          end else begin
            result_next = alu_r;
            z_next      = (alu_r == '0);
            c_next      = alu_c;
            n_next      = alu_r[MSB];
            v_next      = alu_v;
            done_next   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CW'(1);
        // Last of WIDTH steps: acc_step already holds the full product
        if (cnt_reg == CW'(WIDTH - 1)) begin
          result_next = acc_step[WIDTH-1:0];
          z_next      = (acc_step[WIDTH-1:0] == '0);
          c_next      = |acc_step[2*WIDTH-1:WIDTH];
          n_next      = acc_step[MSB];
          v_next      = 1'b0;
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      n_reg      <= 1'b0;
      v_reg      <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      z_reg      <= z_next;
      c_reg      <= c_next;
      n_reg      <= n_next;
      v_reg      <= v_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign result = result_reg;
  assign done   = done_reg;
  assign busy   = busy_reg;
  assign flag_z = z_reg;
  assign flag_c = c_reg;
  assign flag_n = n_reg;
  assign flag_v = v_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed results and {Z,C,N,V} flags,
// done/busy timing, multiply latency, async reset and mid-multiply abort.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] NOT_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic [7:0] result;
  logic       done, busy, flag_z, flag_c, flag_n, flag_v;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .done(done), .busy(busy),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  function automatic logic [3:0] flags();
    return {flag_z, flag_c, flag_n, flag_v};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".result"}, result, 0);
    chk({tag, ".flags"}, flags(), 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  // Present op at a negedge; return 1ns after the accepting edge with start dropped
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic simple(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] er, input logic [3:0] ef);
    issue(o, x, y);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".result"}, result, er);
    chk({tag, ".zcnv"}, flags(), ef);
    chk({tag, ".busy"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, ".done_off"}, done, 0);
  endtask

  // Exactly 8 steps; optionally disturb inputs while busy
  task automatic mul(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] er, input logic [3:0] ef, input bit disturb);
    issue(MUL, x, y);
    chk({tag, ".busy0"}, busy, 1);
    chk({tag, ".done0"}, done, 0);
    for (int k = 1; k <= 8; k++) begin
      if (disturb) begin
        start = 1'b1; op = 3'($urandom_range(0, 7));
        a = 8'($urandom); b = 8'($urandom);
      end
      @(posedge clk); #1;
      if (k < 8) begin
        if (busy !== 1'b1 || done !== 1'b0)
          chk($sformatf("%s.step%0d_busy_done", tag, k), {busy, done}, 2'b10);
      end
    end
    start = 1'b0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".result"}, result, er);
    chk({tag, ".zcnv"}, flags(), ef);
    @(posedge clk); #1;
    chk({tag, ".done_off"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = ADD; a = '0; b = '0;
    #2 rst = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    simple("add_f0_20", ADD, 8'hF0, 8'h20, 8'h10, 4'b0100);

    // Async reset in mid-cycle clears everything without waiting for an edge
    @(posedge clk); #3 rst = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk); rst = 1'b1;

    simple("sub_5_5",  SUB, 8'h05, 8'h05, 8'h00, 4'b1000);
    simple("sub_3_5",  SUB, 8'h03, 8'h05, 8'hFE, 4'b0110);
    simple("add_7f_1", ADD, 8'h7F, 8'h01, 8'h80, 4'b0011);

    mul("mul_0c_0b", 8'h0C, 8'h0B, 8'h84, 4'b0010, 1'b1);
    mul("mul_10_10", 8'h10, 8'h10, 8'h00, 4'b1100, 1'b0);

    // start held high across two simple ops -> adjacent done pulses
    @(negedge clk);
    start = 1'b1; op = AND_; a = 8'hF0; b = 8'h3C;
    @(posedge clk); #1;
    chk("and.done", done, 1);
    chk("and.result", result, 8'h30);
    chk("and.zcnv", flags(), 4'b0000);
    op = OR_;
    @(posedge clk); #1;
    start = 1'b0;
    chk("or.done", done, 1);
    chk("or.result", result, 8'hFC);
    chk("or.zcnv", flags(), 4'b0010);
    @(posedge clk); #1;
    chk("or.done_off", done, 0);
    chk("hold.result", result, 8'hFC);

    simple("shl_81", SHL,  8'h81, 8'h00, 8'h02, 4'b0100);
    simple("shr_01", SHR,  8'h01, 8'h00, 8'h00, 4'b1100);
    simple("not_0f", NOT_, 8'h0F, 8'h00, 8'hF0, 4'b0010);

    // Abort a multiply with reset during its 4th step
    issue(MUL, 8'h0C, 8'h0B);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_zero("mul_abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0)
        chk($sformatf("abort.quiet%0d", k), {done, busy}, 2'b00);
    end
    chk("abort.result", result, 8'h00);

    mul("mul_03_05", 8'h03, 8'h05, 8'h0F, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
